multicycle_ctrl: RTL and testbench

//  Moore FSM sequencing the multicycle MIPS datapath: fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for the multicycle MIPS datapath
// Outputs depend only on state, the wait counter, and the IR fields; zero is only used in BRANCH.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] ULAOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       MDRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       halted,
  output logic       illegal_op
);

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_SXORI = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
    S_LW_RD, S_LW_WB, S_SW_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_done = (cnt_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = 4'd0;
    ULAOp       = 3'b000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    ABWrite     = 1'b0;
    ALUOutWrite = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    MDRWrite    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded
        ABWrite     = 1'b1;
        ALUOutWrite = 1'b1;
        ALUSrcB     = 2'b11;
        case (opcode)
          OP_R:                                  state_d = (funct == FN_BREAK) ? S_HALT : S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_SXORI:  state_d = S_EXEC_I;
          OP_LW, OP_SW:                          state_d = S_ADDR;
          OP_BEQ, OP_BNE:                        state_d = S_BRANCH;
          OP_J:                                  state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA     = 1'b1;
        ULAOp       = 3'b010;
        ALUOutWrite = 1'b1;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALUOutWrite = 1'b1;
        ULAOp       = (opcode == OP_ANDI)  ? 3'b011 :
                      (opcode == OP_SXORI) ? 3'b100 : 3'b000;
        state_d     = S_WB_I;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALUOutWrite = 1'b1;
        state_d     = (opcode == OP_LW) ? S_LW_RD : S_SW_WR;
      end
      S_LW_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_done) begin
          MDRWrite = 1'b1;
          state_d  = S_LW_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_SW_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_done) state_d = S_FETCH;
        else          cnt_d   = cnt_q + 4'd1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ULAOp    = 3'b001;
        PCSource = 2'b01;
        PCWrite  = (opcode == OP_BNE) ? ~zero : zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized instruction-trace bench for multicycle_ctrl
// Each instruction is expanded into its expected per-cycle control vector trace.
module tb_multicycle_ctrl;

  localparam int MW = 2;

  typedef struct packed {
    logic [2:0] ula;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw, irw, abw, aluoutw, memrd, memwr, iord, mdrw, regw, regdst, memtoreg, halted, illegal;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic [2:0] ULAOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic       PCWrite, IRWrite, ABWrite, ALUOutWrite, MemRead, MemWrite, IorD;
  logic       MDRWrite, RegWrite, RegDst, MemtoReg, halted, illegal_op;
  logic [20:0] got_v;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .ULAOp(ULAOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .ABWrite(ABWrite), .ALUOutWrite(ALUOutWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .MDRWrite(MDRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .halted(halted),
    .illegal_op(illegal_op)
  );

  assign got_v = {ULAOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite, ABWrite, ALUOutWrite,
                  MemRead, MemWrite, IorD, MDRWrite, RegWrite, RegDst, MemtoReg, halted, illegal_op};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag, input vec_t e);
    @(negedge clk);
    check(tag, got_v, e);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t fetch_v(input bit last);
    vec_t v = '0;
    v.memrd = 1'b1;
    v.srcb  = 2'b01;
    v.irw   = last;
    v.pcw   = last;
    return v;
  endfunction

  function automatic bit is_known(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h09, 6'h0C, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  task automatic do_fetch();
    for (int i = 0; i <= MW; i++) begin
      zero = 1'($urandom);
      step("fetch", fetch_v(i == MW));
    end
  endtask

  task automatic do_decode(input logic [5:0] op);
    vec_t v = '0;
    v.abw = 1'b1; v.aluoutw = 1'b1; v.srcb = 2'b11;
    v.illegal = !is_known(op);
    zero = 1'($urandom);
    step("decode", v);
  endtask

  // Expected trace for one complete instruction, derived from the instruction class
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    vec_t v;
    opcode = op;
    funct  = fn;
    do_fetch();
    do_decode(op);
    if (!is_known(op)) return;
    zero = 1'($urandom);
    v = '0;
    case (op)
      6'h00: begin
        v.srca = 1'b1; v.ula = 3'b010; v.aluoutw = 1'b1;
        step("exec_r", v);
        v = '0; v.regw = 1'b1; v.regdst = 1'b1;
        step("wb_r", v);
      end
      6'h08, 6'h09, 6'h0C, 6'h0E: begin
        v.srca = 1'b1; v.srcb = 2'b10; v.aluoutw = 1'b1;
        v.ula = (op == 6'h0C) ? 3'b011 : (op == 6'h0E) ? 3'b100 : 3'b000;
        step("exec_i", v);
        v = '0; v.regw = 1'b1;
        step("wb_i", v);
      end
      6'h23, 6'h2B: begin
        v.srca = 1'b1; v.srcb = 2'b10; v.aluoutw = 1'b1;
        step("addr", v);
        for (int i = 0; i <= MW; i++) begin
          v = '0; v.iord = 1'b1;
          if (op == 6'h23) begin v.memrd = 1'b1; v.mdrw = (i == MW); end
          else v.memwr = 1'b1;
          zero = 1'($urandom);
          step((op == 6'h23) ? "lw_rd" : "sw_wr", v);
        end
        if (op == 6'h23) begin
          v = '0; v.regw = 1'b1; v.memtoreg = 1'b1;
          step("lw_wb", v);
        end
      end
      6'h04, 6'h05: begin
        v.srca = 1'b1; v.ula = 3'b001; v.pcsrc = 2'b01;
        v.pcw = (op == 6'h04) ? zero : !zero;
        step("branch", v);
      end
      default: begin
        v.pcsrc = 2'b10; v.pcw = 1'b1;
        step("jump", v);
      end
    endcase
  endtask

  logic [5:0] op_tab [11] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

  initial begin
    vec_t hv;
    logic [5:0] op, fn;
    #1;
    check("reset", got_v, fetch_v(1'b0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed pass through every instruction class
    for (int i = 0; i < 11; i++) run_instr(op_tab[i], 6'h21);

    // Reset in the middle of EXEC_R must abort before WB_R
    opcode = 6'h00; funct = 6'h21;
    do_fetch();
    do_decode(6'h00);
    hv = '0; hv.srca = 1'b1; hv.ula = 3'b010; hv.aluoutw = 1'b1;
    @(negedge clk);
    check("exec_r_pre_reset", got_v, hv);
    #1 reset_n = 1'b0;
    #1 check("reset_mid_exec_r", got_v, fetch_v(1'b0));
    @(posedge clk); #1;
    check("reset_held_edge", got_v, fetch_v(1'b0));
    reset_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 11) == 11) ? 6'($urandom) : op_tab[$urandom_range(0, 10)];
      fn = 6'($urandom);
      if (op == 6'h00 && fn == 6'h0D) fn = 6'h20;
      run_instr(op, fn);
    end

    // break halts until reset
    opcode = 6'h00; funct = 6'h0D;
    do_fetch();
    do_decode(6'h00);
    hv = '0; hv.halted = 1'b1;
    for (int i = 0; i < 100; i++) begin
      zero = 1'($urandom);
      opcode = 6'($urandom);
      step("halt", hv);
    end
    reset_n = 1'b0;
    #1 check("halt_reset", got_v, fetch_v(1'b0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_instr(6'h23, 6'h00);
    run_instr(6'h05, 6'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
